// File: rtl/calc_bcd_converter_if.sv
// Handshake and result bus between the calculator core and the BCD converter.
// The master side issues Start/Bin; the slave side returns status and digits.
interface calc_bcd_converter_if #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   BCD;
    logic [DIGITS-1:0]     Blank;

    modport master (
        output Start, Bin,
        input  Busy, Done, BCD, Blank
    );

    modport slave (
        input  Start, Bin,
        output Busy, Done, BCD, Blank
    );
endinterface

// File: rtl/calc_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a leading-zero blanking mask for the display back ends.
//
// state | meaning
// IDLE  | waiting for Start; BCD/Blank hold the last result
// SHIFT | one input bit shifted into the work digits per edge (WIDTH edges)
// FIN   | publish work digits and blank mask, pulse Done
module calc_bcd_converter #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    calc_bcd_converter_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [1:0]            state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   work;
    logic [4*DIGITS-1:0]   work_adj;
    logic [CNT_W-1:0]      cnt;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [DIGITS-1:0]     blank_q;
    logic [DIGITS-1:0]     blank_next;
    logic                  done_q;
    logic                  upper_zero;

    // Add-3 correction per digit, no carry between digits.
    always_comb begin
        work_adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5)
                work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
    end

    // Digit k is blanked only if it and every digit above it are zero.
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (work[4*k +: 4] == 4'd0);
            blank_next[k] = upper_zero;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            work    <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        shreg <= bus.Bin;
                        work  <= '0;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {work, shreg} <= {work_adj, shreg} << 1;
                    cnt           <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    bcd_q   <= work;
                    blank_q <= blank_next;
                    done_q  <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy  = (state != ST_IDLE);
    assign bus.Done  = done_q;
    assign bus.BCD   = bcd_q;
    assign bus.Blank = blank_q;
endmodule

// File: tb/tb_calc_bcd_converter.sv
// Directed-vector bench for calc_bcd_converter with hand-computed BCD results.
module tb_calc_bcd_converter;
    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;

    calc_bcd_converter_if #(.WIDTH(17), .DIGITS(6)) bus ();

    calc_bcd_converter #(.WIDTH(17), .DIGITS(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench #1 after the accepting edge E0.
    task automatic start_pulse(input logic [16:0] v);
        bus.Bin   = v;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Counts edges from the current point until Done is seen (bounded).
    task automatic wait_done(input string tag, output int n, output logic busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(posedge Clk);
            #1;
            n++;
            if (bus.Done) break;
            if (!bus.Busy) busy_ok = 1'b0;
        end
        if (!bus.Done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no Done within %0d edges", tag, n);
        end
    endtask

    task automatic convert(input string tag, input logic [16:0] v,
                           input logic [23:0] exp_bcd, input logic [5:0] exp_blank);
        int   n;
        logic busy_ok;
        start_pulse(v);
        check({tag, "_busy_rise"}, 32'(bus.Busy), 32'd1);
        wait_done(tag, n, busy_ok);
        check({tag, "_latency"}, 32'(n), 32'd18);
        check({tag, "_busy_hold"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_fall"}, 32'(bus.Busy), 32'd0);
        check({tag, "_bcd"}, 32'(bus.BCD), 32'(exp_bcd));
        check({tag, "_blank"}, 32'(bus.Blank), 32'(exp_blank));
        @(posedge Clk);
        #1;
        check({tag, "_done_1cyc"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int   n;
        logic busy_ok;
        int   done_seen;

        n_tests   = 0;
        n_fail    = 0;
        bus.Start = 1'b0;
        bus.Bin   = '0;
        Reset     = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_bcd", 32'(bus.BCD), 32'h0);
        check("rst_blank", 32'(bus.Blank), 32'b111110);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        convert("zero", 17'd0, 24'h000000, 6'b111110);
        convert("max", 17'd131071, 24'h131071, 6'b000000);
        convert("v12345", 17'd12345, 24'h012345, 6'b100000);
        convert("v7", 17'd7, 24'h000007, 6'b111110);
        convert("v100", 17'd100, 24'h000100, 6'b111000);
        convert("v59049", 17'd59049, 24'h059049, 6'b100000);

        // Start while busy is ignored; Bin change mid-flight has no effect.
        start_pulse(17'd999);
        repeat (4) @(posedge Clk);
        #1;
        start_pulse(17'd5);
        wait_done("ign", n, busy_ok);
        check("ign_latency", 32'(n), 32'd13);
        check("ign_bcd", 32'(bus.BCD), 32'h000999);
        check("ign_blank", 32'(bus.Blank), 32'b111000);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) done_seen++;
        end
        check("ign_no_second_done", 32'(done_seen), 32'd0);
        check("ign_bcd_hold", 32'(bus.BCD), 32'h000999);

        // Back-to-back: second Start issued in the Done cycle.
        start_pulse(17'd500);
        wait_done("b2b_a", n, busy_ok);
        check("b2b_a_bcd", 32'(bus.BCD), 32'h000500);
        start_pulse(17'd42);
        check("b2b_accept", 32'(bus.Busy), 32'd1);
        check("b2b_hold_500", 32'(bus.BCD), 32'h000500);
        wait_done("b2b_b", n, busy_ok);
        check("b2b_b_latency", 32'(n), 32'd18);
        check("b2b_b_bcd", 32'(bus.BCD), 32'h000042);
        check("b2b_b_blank", 32'(bus.Blank), 32'b111100);

        // Reset mid-conversion discards the result.
        start_pulse(17'd8888);
        repeat (9) @(posedge Clk);
        #1;
        check("mid_busy_pre", 32'(bus.Busy), 32'd1);
        check("mid_bcd_pre", 32'(bus.BCD), 32'h000042);
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.Busy), 32'd0);
        check("mid_rst_done", 32'(bus.Done), 32'd0);
        check("mid_rst_bcd", 32'(bus.BCD), 32'h0);
        check("mid_rst_blank", 32'(bus.Blank), 32'b111110);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        convert("after_rst", 17'd8888, 24'h008888, 6'b110000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
